// File: rtl/addr_bus_arbiter.sv
// Address bus arbiter: fixed-priority IRQ/reset vector plus round-robin among
// fetch/decode/alu/sp, with bounded bus locks. All outputs are registered.
module addr_bus_arbiter #(
    parameter int                 SELECTOR_WIDTH = 4,
    parameter int                 MAX_HOLD       = 4,
    parameter int                 HOLD_W         = 3,
    parameter logic [SELECTOR_WIDTH-1:0] IDLE_SEL = 4'd1,
    parameter logic [SELECTOR_WIDTH-1:0] SEL0     = 4'd9,
    parameter logic [SELECTOR_WIDTH-1:0] SEL1     = 4'd10,
    parameter logic [SELECTOR_WIDTH-1:0] SEL2     = 4'd11,
    parameter logic [SELECTOR_WIDTH-1:0] SEL3     = 4'd2,
    parameter logic [SELECTOR_WIDTH-1:0] SEL4     = 4'd13
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4:0]                req,
    input  logic [4:0]                lock,
    output logic [4:0]                gnt,
    output logic [SELECTOR_WIDTH-1:0] in_selector,
    output logic                      bus_busy,
    output logic                      hold_timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    logic [0:0]        state;
    logic [2:0]        owner;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        rr_ptr;

    logic       owner_locked;
    logic       keep;
    logic       forced;
    logic [4:0] excl;
    logic [4:0] elig;
    logic       found;
    logic [2:0] pick;
    logic [1:0] idx;

    function automatic logic [SELECTOR_WIDTH-1:0] sel_of(input logic [2:0] i);
        case (i)
            3'd0:    sel_of = SEL0;
            3'd1:    sel_of = SEL1;
            3'd2:    sel_of = SEL2;
            3'd3:    sel_of = SEL3;
            3'd4:    sel_of = SEL4;
            default: sel_of = IDLE_SEL;
        endcase
    endfunction

    always_comb begin
        owner_locked = (state == ST_OWNED) && req[owner] && lock[owner];
        keep         = owner_locked && (hold_cnt < MAX_HOLD_C);
        forced       = owner_locked && (hold_cnt >= MAX_HOLD_C);
        // A forcibly released owner sits out the arbitration on the release edge.
        excl         = forced ? (5'd1 << owner) : 5'd0;
        elig         = req & ~excl;
    end

    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        idx   = 2'd0;
        if (elig[4]) begin
            found = 1'b1;
            pick  = 3'd4;
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = rr_ptr + 2'(k);
                if (!found && elig[idx]) begin
                    found = 1'b1;
                    pick  = {1'b0, idx};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            owner        <= 3'd0;
            hold_cnt     <= '0;
            rr_ptr       <= 2'd0;
            gnt          <= 5'd0;
            in_selector  <= '0;
            bus_busy     <= 1'b0;
            hold_timeout <= 1'b0;
        end else if (keep) begin
            hold_cnt     <= hold_cnt + 1'b1;
            hold_timeout <= 1'b0;
        end else if (found) begin
            state        <= ST_OWNED;
            owner        <= pick;
            hold_cnt     <= HOLD_W'(1);
            gnt          <= 5'd1 << pick;
            in_selector  <= sel_of(pick);
            bus_busy     <= 1'b1;
            hold_timeout <= forced;
            if (!pick[2]) begin
                rr_ptr <= pick[1:0] + 2'd1;
            end
        end else begin
            state        <= ST_IDLE;
            owner        <= 3'd0;
            hold_cnt     <= '0;
            gnt          <= 5'd0;
            in_selector  <= IDLE_SEL;
            bus_busy     <= 1'b0;
            hold_timeout <= forced;
        end
    end

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Bench for addr_bus_arbiter: directed vector table, reset sequences and
// randomized traffic against an integer-level reference model.
module tb_addr_bus_arbiter;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] req;
  logic [4:0] lock;
  logic [4:0] gnt;
  logic [3:0] in_selector;
  logic       bus_busy;
  logic       hold_timeout;

  always #5 clk = ~clk;

  addr_bus_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .lock        (lock),
    .gnt         (gnt),
    .in_selector (in_selector),
    .bus_busy    (bus_busy),
    .hold_timeout(hold_timeout)
  );

  typedef struct {
    logic [4:0] req;
    logic [4:0] lock;
    logic [4:0] gnt;
    logic [3:0] sel;
    logic       to;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  sel_tab[5] = '{4'd9, 4'd10, 4'd11, 4'd2, 4'd13};

  // Reference model: owner index (-1 = idle), cycles held, next RR start.
  int m_owner;
  int m_held;
  int m_rr;

  wire [10:0] dut_out = {gnt, in_selector, bus_busy, hold_timeout};

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_rr    = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [4:0] r, input logic [4:0] l);
    bit forced = 0;
    bit keep   = 0;
    int cand   = -1;
    logic [4:0] g;
    logic [3:0] s;
    if (m_owner >= 0 && r[m_owner] && l[m_owner]) begin
      if (m_held < MAX_HOLD) keep = 1;
      else forced = 1;
    end
    if (keep) begin
      m_held++;
    end else begin
      if (r[4] && !(forced && m_owner == 4)) cand = 4;
      else begin
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (m_rr + k) % 4;
          if (cand < 0 && r[i] && !(forced && m_owner == i)) cand = i;
        end
      end
      if (cand >= 0) begin
        m_owner = cand;
        m_held  = 1;
        if (cand < 4) m_rr = (cand + 1) % 4;
      end else begin
        m_owner = -1;
        m_held  = 0;
      end
    end
    g = (m_owner >= 0) ? (5'd1 << m_owner) : 5'd0;
    s = (m_owner >= 0) ? sel_tab[m_owner] : 4'd1;
    exp_q.push_back({g, s, (m_owner >= 0), forced});
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual gnt=%b sel=%0d busy=%b to=%b, required gnt=%b sel=%0d busy=%b to=%b",
               name, act[10:6], act[5:2], act[1], act[0], exp[10:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic cycle(input logic [4:0] r, input logic [4:0] l, input string name);
    req  = r;
    lock = l;
    model_step(r, l);
    @(posedge clk);
    #1;
    check(name, dut_out, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic add(input logic [4:0] r, input logic [4:0] l, input logic [4:0] g,
                     input logic [3:0] s, input logic t);
    vec_t v;
    v.req = r; v.lock = l; v.gnt = g; v.sel = s; v.to = t;
    tbl.push_back(v);
  endtask

  initial begin
    // single requests
    add(5'b00001, 5'b0, 5'b00001, 4'd9,  1'b0);
    add(5'b00000, 5'b0, 5'b00000, 4'd1,  1'b0);
    add(5'b00010, 5'b0, 5'b00010, 4'd10, 1'b0);
    add(5'b00000, 5'b0, 5'b00000, 4'd1,  1'b0);
    add(5'b00100, 5'b0, 5'b00100, 4'd11, 1'b0);
    add(5'b00000, 5'b0, 5'b00000, 4'd1,  1'b0);
    add(5'b01000, 5'b0, 5'b01000, 4'd2,  1'b0);
    add(5'b00000, 5'b0, 5'b00000, 4'd1,  1'b0);
    add(5'b10000, 5'b0, 5'b10000, 4'd13, 1'b0);
    add(5'b00000, 5'b0, 5'b00000, 4'd1,  1'b0);
    // round-robin with no locks
    add(5'b01111, 5'b0, 5'b00001, 4'd9,  1'b0);
    add(5'b01111, 5'b0, 5'b00010, 4'd10, 1'b0);
    add(5'b01111, 5'b0, 5'b00100, 4'd11, 1'b0);
    add(5'b01111, 5'b0, 5'b01000, 4'd2,  1'b0);
    add(5'b01111, 5'b0, 5'b00001, 4'd9,  1'b0);
    add(5'b00000, 5'b0, 5'b00000, 4'd1,  1'b0);
    add(5'b01000, 5'b0, 5'b01000, 4'd2,  1'b0);
    add(5'b00000, 5'b0, 5'b00000, 4'd1,  1'b0);
    // vector priority and 2-cycle vector lock, rr pointer left at 0
    add(5'b10011, 5'b10000, 5'b10000, 4'd13, 1'b0);
    add(5'b10011, 5'b10000, 5'b10000, 4'd13, 1'b0);
    add(5'b00011, 5'b00000, 5'b00001, 4'd9,  1'b0);
    add(5'b00000, 5'b00000, 5'b00000, 4'd1,  1'b0);
    // hold timeout at MAX_HOLD, then hand-over with no bubble
    add(5'b00100, 5'b00100, 5'b00100, 4'd11, 1'b0);
    add(5'b00101, 5'b00100, 5'b00100, 4'd11, 1'b0);
    add(5'b00101, 5'b00100, 5'b00100, 4'd11, 1'b0);
    add(5'b00101, 5'b00100, 5'b00100, 4'd11, 1'b0);
    add(5'b00101, 5'b00100, 5'b00001, 4'd9,  1'b1);
    add(5'b00100, 5'b00100, 5'b00100, 4'd11, 1'b0);
    add(5'b00000, 5'b00000, 5'b00000, 4'd1,  1'b0);
    // lock without request is ignored
    add(5'b00000, 5'b11111, 5'b00000, 4'd1,  1'b0);

    // reset with all requests asserted
    reset_n = 1'b0;
    req     = 5'h1F;
    lock    = 5'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out, 11'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req     = 5'h00;
    model_reset();
    cycle(5'b0, 5'b0, "post_reset_idle_sel");

    foreach (tbl[i]) begin
      cycle(tbl[i].req, tbl[i].lock, $sformatf("model_vec%0d", i));
      check($sformatf("table_vec%0d", i), dut_out,
            {tbl[i].gnt, tbl[i].sel, |tbl[i].gnt, tbl[i].to});
    end

    // asynchronous reset in the middle of a lock
    cycle(5'b00100, 5'b00100, "lock_a");
    cycle(5'b00100, 5'b00100, "lock_b");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_mid_lock", dut_out, 11'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req     = 5'b0;
    lock    = 5'b0;
    model_reset();

    // randomized traffic, locks biased on so timeouts occur
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r;
      logic [4:0] l;
      r = 5'($urandom_range(0, 31));
      l = ($urandom_range(0, 3) != 0) ? 5'h1F : 5'($urandom_range(0, 31));
      cycle(r, l, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
